// File: rtl/gpio_input_conditioner.sv
// Per-input synchroniser, debounce filter, edge pulses and sticky interrupt status.
// Define GPIO_COND_GLITCH_CNT_EN to build the aborted-transition counter on glitch_count.
module gpio_input_conditioner #(
  parameter int                    NUM_INPUTS      = 6,
  parameter int                    SYNC_STAGES     = 2,
  parameter int                    DEBOUNCE_CYCLES = 500000,
  parameter logic [NUM_INPUTS-1:0] RESET_VALUE     = '0
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] clean_out,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse,
  input  logic [NUM_INPUTS-1:0] irq_rise_en,
  input  logic [NUM_INPUTS-1:0] irq_fall_en,
  input  logic [NUM_INPUTS-1:0] irq_clear,
  output logic [NUM_INPUTS-1:0] irq_status,
  output logic                  interrupt,
  output logic [15:0]           glitch_count,
  input  logic                  glitch_clear
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_INPUTS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_INPUTS-1:0] sync_d [SYNC_STAGES];
  logic [NUM_INPUTS-1:0] sync_bits;
  logic [NUM_INPUTS-1:0] clean_q, clean_d;
  logic [NUM_INPUTS-1:0] rise_q, rise_d;
  logic [NUM_INPUTS-1:0] fall_q, fall_d;
  logic [NUM_INPUTS-1:0] irq_status_q, irq_status_d;
`ifdef GPIO_COND_GLITCH_CNT_EN
  logic [NUM_INPUTS-1:0] abort_bits;
`endif

  always_comb begin
    sync_d[0] = raw_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int s = 0; s < SYNC_STAGES; s++) begin
      if (rst) sync_q[s] <= RESET_VALUE;
      else     sync_q[s] <= sync_d[s];
    end
  end

  assign sync_bits = sync_q[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             clean_bit_d;

      // Counter only runs while the synchronised level disagrees with the accepted one.
      always_comb begin
        cnt_d       = '0;
        clean_bit_d = clean_q[gi];
        if (sync_bits[gi] != clean_q[gi]) begin
          if (cnt_q == CNT_MAX) clean_bit_d = sync_bits[gi];
          else                  cnt_d       = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge sys_clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign clean_d[gi] = clean_bit_d;
`ifdef GPIO_COND_GLITCH_CNT_EN
      assign abort_bits[gi] = (cnt_q != '0) && (sync_bits[gi] == clean_q[gi]);
`endif
    end
  endgenerate

  // A newly raised pending bit beats a clear strobe in the same cycle.
  always_comb begin
    rise_d       = clean_d & ~clean_q;
    fall_d       = ~clean_d & clean_q;
    irq_status_d = (irq_status_q & ~irq_clear) | (rise_q & irq_rise_en) | (fall_q & irq_fall_en);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      clean_q      <= RESET_VALUE;
      rise_q       <= '0;
      fall_q       <= '0;
      irq_status_q <= '0;
    end else begin
      clean_q      <= clean_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      irq_status_q <= irq_status_d;
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign irq_status = irq_status_q;
  assign interrupt  = |irq_status_q;

`ifdef GPIO_COND_GLITCH_CNT_EN
  logic [15:0] glitch_count_q, glitch_count_d;

  always_comb begin
    glitch_count_d = glitch_count_q;
    if (glitch_clear)                                     glitch_count_d = '0;
    else if ((|abort_bits) && (glitch_count_q != 16'hFFFF)) glitch_count_d = glitch_count_q + 16'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) glitch_count_q <= '0;
    else     glitch_count_q <= glitch_count_d;
  end

  assign glitch_count = glitch_count_q;
`else
  logic unused_glitch_clear;
  assign unused_glitch_clear = glitch_clear;
  assign glitch_count        = '0;
`endif

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Conditions raw board inputs (2 slide switches, 4 push buttons) before the GPIO subsystem register file samples them.
- Per bit: synchroniser, debounce filter, rise/fall edge detection, sticky interrupt-status bits.
- Feeds clean levels and a combined interrupt request to the GPIO register block, which owns enable and clear writes.

Parameters:
- NUM_INPUTS, 6, number of conditioned inputs; bits [1:0] are switches, bits [5:2] are buttons.
- SYNC_STAGES, 2, synchroniser flop depth; minimum 2.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a level is accepted (10 ms at 50 MHz); minimum 2.
- RESET_VALUE, 0, NUM_INPUTS-bit reset level for the synchroniser and clean_out.

Ports:
- sys_clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- raw_in  input  NUM_INPUTS  asynchronous pad inputs.
- clean_out  output  NUM_INPUTS  debounced levels.
- rise_pulse  output  NUM_INPUTS  one-cycle pulse when clean_out goes 0->1.
- fall_pulse  output  NUM_INPUTS  one-cycle pulse when clean_out goes 1->0.
- irq_rise_en  input  NUM_INPUTS  per-bit rising-edge interrupt enable.
- irq_fall_en  input  NUM_INPUTS  per-bit falling-edge interrupt enable.
- irq_clear  input  NUM_INPUTS  one-cycle write-1-to-clear strobe for irq_status.
- irq_status  output  NUM_INPUTS  sticky pending bits.
- interrupt  output  1  OR of irq_status.
- glitch_count  output  16  aborted-transition counter (optional feature).
- glitch_clear  input  1  clears glitch_count.

Behaviour:
- Reset is sampled on the sys_clk rising edge only, and rst has priority over all other activity, including mid-debounce.
- Reset values:
  - Synchroniser flops and clean_out = RESET_VALUE.
  - Debounce counters = 0.
  - rise_pulse, fall_pulse, irq_status, interrupt, glitch_count = 0.
- No edge pulse is generated on reset release.
- Synchroniser: the SYNC_STAGES-deep flop chain gives sync[i].
- Debounce, per bit, counter width $clog2(DEBOUNCE_CYCLES):
  - sync == clean_out: counter := 0.
  - sync != clean_out and counter < DEBOUNCE_CYCLES-1: counter += 1.
  - sync != clean_out and counter == DEBOUNCE_CYCLES-1: clean_out := sync and counter := 0.
  - Net effect: clean_out changes DEBOUNCE_CYCLES edges after sync first differs, provided sync stays different throughout. Total raw->clean latency is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - If sync returns to clean_out before acceptance, the counter resets and there is no output change.
  - The counter never wraps.
- Edges: rise_pulse and fall_pulse are registered and assert the same cycle clean_out changes, for exactly one cycle. Both pulses are never high together on one bit.
- Interrupt status, per bit:
  - Set when (rise_pulse & irq_rise_en) | (fall_pulse & irq_fall_en).
  - Cleared by irq_clear.
  - If set and clear occur in the same cycle, set wins.
  - Enables act on the current cycle's value.
  - Deasserting an enable does not clear an already-pending bit.
- interrupt: combinational OR of irq_status, so it is high the same cycle any bit is set.
- All bits are fully independent; simultaneous edges on several bits are each captured.

Optional Feature:
- Macro: GPIO_COND_GLITCH_CNT_EN.
- Defined:
  - glitch_count increments by 1 each cycle in which any bit's counter is non-zero and sync equals clean_out (an aborted transition).
  - Only one increment per cycle, regardless of how many bits abort.
  - Saturates at 16'hFFFF.
  - glitch_clear := 0, with priority over an increment in the same cycle.
- Undefined: glitch_count tied to 0, glitch_clear ignored, no counter logic synthesised.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=8, SYNC_STAGES=2, RESET_VALUE=0.)
- Reset, then raw_in[2] held 1 -> clean_out[2] rises exactly 10 cycles after raw change; rise_pulse[2] high 1 cycle; no pulses on other bits.
- raw_in[3] toggles 1 for 5 cycles then 0 -> clean_out stays 0, no pulses; with GPIO_COND_GLITCH_CNT_EN, glitch_count = 1.
- irq_rise_en=6'b000100, press then release bit 2 -> irq_status=6'b000100 and interrupt=1 after press; no change on release; irq_clear[2] pulse -> status 0 next cycle.
- irq_fall_en[5]=1, release edge coincident with irq_clear[5] -> irq_status[5] remains 1 (set wins).
- Assert rst while raw_in[4] is mid-debounce (counter=5) -> all outputs 0 next cycle; after release, a stable 1 needs the full 10 cycles again.
- Simultaneous raw_in 6'b000000->6'b111111 -> all six clean_out bits and rise_pulse bits change in the same cycle.
